// File: rtl/disp_pkg.sv
// Constants shared by the display path (game logic, scanner, segment decoder).
// Also holds the leading-zero mask helper used at each snapshot.
package disp_pkg;

    localparam logic [7:0] DIG_OFF   = 8'hFF;
    localparam logic [3:0] NUM_BLANK = 4'hF;
    localparam int         BCD_W     = 4;
    localparam int         MAX_DIG   = 8;

    // Walk from the top scanned digit down, masking zeros until the first nonzero digit.
    // Digit 0 is never masked, so a value of zero still shows a single 0.
    function automatic logic [MAX_DIG-1:0] lz_mask(
        input logic [MAX_DIG*BCD_W-1:0] digits,
        input int                       n_dig
    );
        logic [MAX_DIG-1:0] m;
        logic               leading;
        m       = '0;
        leading = 1'b1;
        for (int i = MAX_DIG - 1; i >= 1; i--) begin
            if (i < n_dig) begin
                if (leading && digits[i*BCD_W +: BCD_W] == 4'd0) begin
                    m[i] = 1'b1;
                end else begin
                    leading = 1'b0;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/tick_div.sv
// Slot prescaler: counts 0..DIV-1, pulses wrap on the last count, clr forces zero.
module tick_div #(
    parameter int DIV = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    output logic [$clog2(DIV)-1:0] count,
    output logic                   wrap
);

    localparam int              PW   = $clog2(DIV);
    localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

    assign wrap = !clr && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr || wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed 8-digit scanner: snapshots BCD once per frame, drives decoder code
// and active-low digit selects with a dark guard interval at the start of each slot.
module disp_scan
    import disp_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int GUARD = 16,
    parameter int N_DIG = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] bcd,
    input  logic        blank_lz,
    output logic [3:0]  num,
    output logic [7:0]  dig,
    output logic        frame
);

    localparam int         PW       = $clog2(DIV);
    localparam logic [2:0] LAST_IDX = 3'(N_DIG - 1);

    logic [PW-1:0] pre;
    logic [PW-1:0] pre_n;
    logic          wrap;
    logic          clr;
    logic [2:0]    idx;
    logic [2:0]    idx_n;
    logic [31:0]   shadow;
    logic [31:0]   shadow_n;
    logic [7:0]    mask;
    logic [7:0]    mask_n;
    logic          pend;
    logic          pend_n;
    logic          snap;
    logic [3:0]    num_n;
    logic [7:0]    dig_n;

    // The prescaler restarts whenever the scan is held or a fresh frame is being started.
    assign clr = !en || pend;

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .count (pre),
        .wrap  (wrap)
    );

    always_comb begin
        pre_n    = pre;
        idx_n    = idx;
        shadow_n = shadow;
        mask_n   = mask;
        pend_n   = pend;
        snap     = 1'b0;

        if (!en) begin
            pre_n  = '0;
            idx_n  = '0;
            pend_n = 1'b1;
        end else if (pend) begin
            snap   = 1'b1;
            pend_n = 1'b0;
            pre_n  = '0;
            idx_n  = '0;
        end else begin
            pre_n = wrap ? '0 : pre + 1'b1;
            if (wrap) begin
                if (idx == LAST_IDX) begin
                    idx_n = '0;
                    snap  = 1'b1;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end

        if (snap) begin
            shadow_n = bcd;
            mask_n   = blank_lz ? lz_mask(bcd, N_DIG) : '0;
        end

        // Outputs are derived from next-state so they move in the same cycle as the scan.
        if (!en || mask_n[idx_n]) begin
            num_n = NUM_BLANK;
        end else begin
            num_n = shadow_n[{idx_n, 2'b00} +: BCD_W];
        end

        if (!en || (32'(pre_n) < 32'(GUARD))) begin
            dig_n = DIG_OFF;
        end else begin
            dig_n = ~(8'b1 << idx_n);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx    <= '0;
            shadow <= '0;
            mask   <= '0;
            pend   <= 1'b1;
            num    <= NUM_BLANK;
            dig    <= DIG_OFF;
            frame  <= 1'b0;
        end else begin
            idx    <= idx_n;
            shadow <= shadow_n;
            mask   <= mask_n;
            pend   <= pend_n;
            num    <= num_n;
            dig    <= dig_n;
            frame  <= snap;
        end
    end

endmodule

// File: doc/disp_scan.md
# disp_scan

Time-multiplexed digit scanner for the count_game 8-digit seven-segment display. Sits directly upstream of the segment decoder: takes eight packed BCD digits from the game logic, snapshots them once per frame, and walks the digits one slot at a time, driving the 4-bit code the decoder converts to segments and the active-low digit-select lines. Adds per-slot ghosting guard time and optional leading-zero blanking.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range is 2 or greater.
- GUARD, 16: dead cycles at the start of each slot with all digits off; must satisfy 0 ≤ GUARD < DIV.
- N_DIG, 8: number of digits scanned, 1..8. Select bits at index N_DIG or above stay high.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scan enable. When low, the display is dark and the scan is held at its start.
- bcd  in  32  digits. Digit i is at bcd[4i+3:4i]; digit 0 is the rightmost digit.
- blank_lz  in  1  leading-zero blanking enable. Sampled at each snapshot.
- num  out  4  code sent to the decoder. 4'hF means blank, which the decoder maps to all segments off.
- dig  out  8  active-low digit select. At most one bit is low at any time.
- frame  out  1  one-cycle pulse in the cycle a new snapshot is taken.

## Operation
- State:
  - pre: prescaler, 0..DIV-1.
  - idx: current digit, 0..N_DIG-1.
  - shadow: 32-bit snapshot of bcd.
  - mask: N_DIG-bit blank mask.
  - pend: flag requesting a snapshot on the next enabled cycle.
- Reset values: pre=0, idx=0, shadow=0, mask=0, pend=1, num=4'hF, dig=8'hFF, frame=0.
- en low: pre and idx are forced to 0 and pend is set. Registered outputs go to num=4'hF, dig=8'hFF, frame=0. shadow and mask are held.
- en high with pend=1: take a snapshot this cycle, clear pend, and set pre=0, idx=0.
- en high otherwise: pre increments. When pre=DIV-1, pre wraps to 0 and idx advances.
  - If idx=N_DIG-1, idx wraps to 0 and a snapshot is taken in the same cycle.
- Snapshot action:
  - shadow takes bcd.
  - mask is computed from that bcd and blank_lz. With blank_lz=1, digits from N_DIG-1 downward are masked while they equal 0. The scan stops at the first nonzero digit. Digit 0 is never masked. With blank_lz=0, mask=0.
  - frame is asserted on the following cycle.
- Digit codes 10–15 in bcd are passed through unchanged. They count as nonzero for blanking purposes.
- Outputs are registered from the next-state values, so num, dig and frame change in the cycle the state changes:
  - num = 4'hF if mask[idx], otherwise shadow[4·idx+3:4·idx].
  - dig = 8'hFF if en=0 or pre < GUARD. Otherwise all bits are high except bit idx, which is low.
- Changes on bcd in mid-frame have no visible effect until the next snapshot, so no tearing occurs.
- A reset assertion at any time, including mid-slot, immediately forces the reset values. Scanning restarts from digit 0 with a fresh snapshot on the first enabled cycle after reset is released.

## Timing
- Slot length is DIV cycles: GUARD cycles dark, then DIV−GUARD cycles with dig low.
- Frame length is N_DIG·DIV cycles. frame pulses are exactly N_DIG·DIV cycles apart while en stays high.
- First enabled cycle after reset (or after en rises):
  - The snapshot is taken in that cycle.
  - frame, num for digit 0, and dig=FF (if GUARD>0) are visible one cycle later.
- num changes only at slot boundaries, while dig is all high. This holds when GUARD ≥ 1.
- Dropping en takes effect on the outputs one cycle later.

## Structure
- Shared package disp_pkg holds:
  - DIG_OFF = 8'hFF
  - NUM_BLANK = 4'hF
  - BCD_W = 4
  - the digit-count constant 8
- These are shared with the decoder and the game logic.
- One sub-module, tick_div, provides the prescaler. It has parameter DIV, inputs clk, rst and clr, and outputs the count and a wrap pulse. All other logic stays in disp_scan.

## Test plan
Parameters for all scenarios: DIV=4, GUARD=1, N_DIG=8.
1. Reset, then en=1, bcd=32'h87654321, blank_lz=0.
   - frame pulses one cycle after en.
   - dig sequence per slot is FF, FE, FE, FE, then FF, FD, … through 7F.
   - num is 1, 2, …, 8 in that order.
   - frame repeats every 32 cycles.
2. bcd=32'h00000305, blank_lz=1.
   - Digits 7..3 show num=F with their dig bits low.
   - Digits 2..0 show 3, 0, 5.
   - With bcd=0, only digit 0 shows 0.
3. bcd changes from 32'h11111111 to 32'h22222222 during digit 3.
   - Digits 4..7 still show 1.
   - The change appears only after the next frame pulse.
4. Drop en during digit 5.
   - The next cycle gives dig=FF and num=F.
   - When en is raised again, the scan restarts at digit 0 with a fresh snapshot and a frame pulse.
5. Assert rst mid-slot.
   - Outputs go to num=F, dig=FF, frame=0 asynchronously, before the next clk edge.
   - After release, the sequence matches scenario 1 from the start.
6. bcd=32'hA0000000, blank_lz=1.
   - Digit 7 shows num=A.
   - The zeros below it are not masked.
